cfg_chain_loader: RTL and testbench
===================================

CFG_CHAIN_LOADER -- requirements
Module: cfg_chain_loader

Interface
REQ-001 The parameters SHALL be:
- CHAIN_LEN, default 8: configuration-chain length in bits.
- WORD_W, default 8: width of the input data word.
REQ-002 The ports SHALL be (name, direction, width, meaning):
- prog_clk, in, 1: the only clock.
- prog_rst_n, in, 1: reset, asynchronous, active-low.
- start, in, 1: begin a load.
- word_data, in, WORD_W: bitstream word, MSB shifted first.
- word_valid, in, 1: word_data is valid.
- word_ready, out, 1: loader accepts a word.
- ccff_head, out, 1: serial bit into the configuration chain head.
- ccff_clk_en, out, 1: chain prog_clk gate enable; the chain shifts only on edges where this is 1.
- ccff_tail, in, 1: serial bit returned from the chain tail.
- busy, out, 1: load in progress.
- done, out, 1: single-cycle completion pulse.
- error, out, 1: readback mismatch flag (sticky).

Function
REQ-003 The FSM SHALL have four states:
- IDLE.
- FILL: no bits held; word_ready=1.
- SHIFT: a word is held; bits are emitted.
- DONE.
REQ-004 IDLE SHALL go to FILL on start=1; start SHALL be ignored in every state except IDLE.
REQ-005 A word SHALL be accepted only on a prog_clk edge where word_valid && word_ready; on acceptance it is loaded into a WORD_W shift register and the FSM enters SHIFT.
REQ-006 In SHIFT, each cycle SHALL register ccff_head = current MSB and ccff_clk_en = 1, shift the register left, and increment the bit counter, whose width is $clog2(2*CHAIN_LEN+1).
REQ-007 word_ready SHALL also be 1 in SHIFT during the cycle the last bit of the held word is emitted, so back-to-back words produce a continuous ccff_clk_en.
REQ-008 Whenever no bit is emitted (FILL, or a stall with word_valid=0), ccff_clk_en SHALL be 0 and ccff_head SHALL hold its last value.
REQ-009 The pass length SHALL be CHAIN_LEN bits; ceil(CHAIN_LEN/WORD_W) words are consumed per pass, and the unused low-order bits of the final word SHALL be discarded without asserting ccff_clk_en.
REQ-010 After the final bit of the final pass is emitted, the FSM SHALL enter DONE, assert done for exactly 1 cycle, then return to IDLE.
REQ-011 busy SHALL be 1 in FILL, SHIFT and DONE, and 0 in IDLE.
REQ-012 word_ready SHALL be 0 in IDLE and DONE, and 0 in SHIFT except as stated in REQ-007.

Reset
REQ-013 Asserting prog_rst_n low SHALL immediately force the FSM to IDLE and all counters to 0, and drive word_ready=0, ccff_head=0, ccff_clk_en=0, busy=0, done=0, error=0.
REQ-014 A reset in the middle of a load SHALL abandon the load with no further ccff_clk_en pulses; the partial chain contents are undefined, and the host SHALL restart with start.

Configuration
REQ-015 The readback feature SHALL be compiled in by macro CFG_CHAIN_READBACK_EN.
- With the macro: the loader SHALL run two passes (2*CHAIN_LEN bits). The host resends the identical stream for pass 2.
- With the macro: on every pass-2 cycle where ccff_clk_en=1, ccff_tail SHALL be compared against the bit being emitted on ccff_head.
- With the macro: any mismatch SHALL set error, which stays 1 until the next accepted start.
- Without the macro: there SHALL be a single pass, ccff_tail SHALL be unused, and error SHALL be tied to 0.

Structure
REQ-016 The FSM state enum, a default CHAIN_LEN/WORD_W localparam pair, and the bit-counter width function SHALL reside in shared package cfg_loader_pkg.
REQ-017 A single sub-module cfg_word_serializer SHALL hold the word shift register, the per-word bit counter and the last-bit detection; the FSM, pass counter and readback compare SHALL remain in cfg_chain_loader.

Verification
REQ-018 The bench SHALL model the chain as a CHAIN_LEN-bit shift register clocked by prog_clk && ccff_clk_en, and SHALL cover the following scenarios:
- Basic load, CHAIN_LEN=8, WORD_W=8: start, then word 0xA5 -> ccff_head = 1,0,1,0,0,1,0,1 on 8 consecutive enabled cycles; model contents 0xA5; done pulses for 1 cycle; busy falls the following cycle.
- Stall and partial word, CHAIN_LEN=12: words 0xF0 and 0x9C, with word_valid low for 3 cycles between them -> ccff_clk_en is 0 during the gap; exactly 12 enabled cycles; bits 1111_0000_1001 land in the chain; the low nibble 0xC is dropped.
- Readback pass, CFG_CHAIN_READBACK_EN, CHAIN_LEN=8: 0x3C sent twice -> 16 enabled cycles; error=0; done=1 once.
- Readback fault, same setup: the bench flips ccff_tail on pass-2 bit 5 -> error=1 at done and still 1 in IDLE; the next start clears it to 0.
- Reset mid-shift: prog_rst_n low after 3 enabled bits -> all outputs 0 in the same cycle; no ccff_clk_en pulses until a new start.
- start held high throughout a load -> exactly one load occurs; done=1 once; the FSM re-enters FILL only after returning to IDLE.

Source files
------------

// File: rtl/cfg_loader_pkg.sv
// Shared definitions for the configuration-chain loader: FSM states,
// default geometry and the pass bit-counter width helper.
package cfg_loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } loader_state_t;

  localparam int DEFAULT_CHAIN_LEN = 8;
  localparam int DEFAULT_WORD_W    = 8;

  // Wide enough to count both passes of a readback load.
  function automatic int bit_cnt_width(input int chain_len);
    return $clog2(2 * chain_len + 1);
  endfunction

endpackage

// File: rtl/cfg_word_serializer.sv
// Holds one bitstream word and presents it MSB first, one bit per shift,
// flagging the last bit of the word (or an early cut at a pass boundary).
module cfg_word_serializer
  import cfg_loader_pkg::*;
#(
  parameter int WORD_W = DEFAULT_WORD_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              shift,
  input  logic              force_last,
  input  logic [WORD_W-1:0] word_in,
  output logic              msb,
  output logic              last_bit
);

  localparam int IDX_W = $clog2(WORD_W + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 1);

  logic [WORD_W-1:0] sreg;
  logic [IDX_W-1:0]  bit_idx;

  // A load on the last-bit cycle replaces the word being drained.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg    <= '0;
      bit_idx <= '0;
    end else if (load) begin
      sreg    <= word_in;
      bit_idx <= '0;
    end else if (shift) begin
      sreg    <= sreg << 1;
      bit_idx <= bit_idx + 1'b1;
    end
  end

  assign msb      = sreg[WORD_W-1];
  assign last_bit = (bit_idx == LAST_IDX) || force_last;

endmodule

// File: rtl/cfg_chain_loader.sv
// Streams host words serially into a configuration flip-flop chain.
// Define CFG_CHAIN_READBACK_EN for a second, verified pass (sticky error).
module cfg_chain_loader
  import cfg_loader_pkg::*;
#(
  parameter int CHAIN_LEN = DEFAULT_CHAIN_LEN,
  parameter int WORD_W    = DEFAULT_WORD_W
) (
  input  logic              prog_clk,
  input  logic              prog_rst_n,
  input  logic              start,
  input  logic [WORD_W-1:0] word_data,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              ccff_head,
  output logic              ccff_clk_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int CNT_W = bit_cnt_width(CHAIN_LEN);
`ifdef CFG_CHAIN_READBACK_EN
  localparam int NUM_PASSES = 2;
`else
  localparam int NUM_PASSES = 1;
`endif
  localparam logic [CNT_W-1:0] PASS1_LAST = CNT_W'(CHAIN_LEN - 1);
  localparam logic [CNT_W-1:0] FINAL_LAST = CNT_W'(NUM_PASSES * CHAIN_LEN - 1);

  loader_state_t state, state_n;
  logic [CNT_W-1:0] bit_cnt;
  logic shift_en, accept, start_ok;
  logic ser_msb, ser_last;
  logic pass_end, final_bit;

  assign start_ok  = (state == IDLE) && start;
  assign accept    = word_valid && word_ready;
  assign pass_end  = (bit_cnt == PASS1_LAST) || (bit_cnt == FINAL_LAST);
  assign final_bit = (bit_cnt == FINAL_LAST);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

  cfg_word_serializer #(
    .WORD_W(WORD_W)
  ) u_serializer (
    .clk       (prog_clk),
    .rst_n     (prog_rst_n),
    .load      (accept),
    .shift     (shift_en),
    .force_last(pass_end),
    .word_in   (word_data),
    .msb       (ser_msb),
    .last_bit  (ser_last)
  );

  always_ff @(posedge prog_clk or negedge prog_rst_n) begin
    if (!prog_rst_n) state <= IDLE;
    else             state <= state_n;
  end

  // Opening word_ready on the last bit lets the next word follow with no
  // hole in ccff_clk_en; the final bit of the load never accepts a word.
  always_comb begin
    state_n    = state;
    word_ready = 1'b0;
    shift_en   = 1'b0;
    case (state)
      IDLE: if (start) state_n = FILL;
      FILL: begin
        word_ready = 1'b1;
        if (word_valid) state_n = SHIFT;
      end
      SHIFT: begin
        shift_en = 1'b1;
        if (ser_last) begin
          if (final_bit) begin
            state_n = DONE;
          end else begin
            word_ready = 1'b1;
            state_n    = word_valid ? SHIFT : FILL;
          end
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge prog_clk or negedge prog_rst_n) begin
    if (!prog_rst_n) begin
      bit_cnt     <= '0;
      ccff_head   <= 1'b0;
      ccff_clk_en <= 1'b0;
    end else begin
      ccff_clk_en <= shift_en;
      if (shift_en) ccff_head <= ser_msb;
      if (start_ok)      bit_cnt <= '0;
      else if (shift_en) bit_cnt <= bit_cnt + 1'b1;
    end
  end

`ifdef CFG_CHAIN_READBACK_EN
  logic pass_cnt;
  logic head_pass2;

  // The tail holds the pass-1 bit that pairs with the pass-2 bit on the head.
  always_ff @(posedge prog_clk or negedge prog_rst_n) begin
    if (!prog_rst_n) begin
      pass_cnt   <= 1'b0;
      head_pass2 <= 1'b0;
      error      <= 1'b0;
    end else begin
      head_pass2 <= shift_en && pass_cnt;
      if (start_ok) begin
        pass_cnt <= 1'b0;
        error    <= 1'b0;
      end else begin
        if (shift_en && pass_end) pass_cnt <= 1'b1;
        if (ccff_clk_en && head_pass2 && (ccff_tail != ccff_head)) error <= 1'b1;
      end
    end
  end
`else
  logic unused_tail;
  assign unused_tail = ccff_tail;
  assign error       = 1'b0;
`endif

endmodule

// File: tb/tb_cfg_chain_loader.sv
// Self-checking bench for cfg_chain_loader: two instances (8- and 12-bit
// chains) against a behavioural chain model; honours CFG_CHAIN_READBACK_EN.
module tb_cfg_chain_loader;

  localparam int CL0 = 8;
  localparam int CL1 = 12;
`ifdef CFG_CHAIN_READBACK_EN
  localparam int NP = 2;
`else
  localparam int NP = 1;
`endif

  logic prog_clk = 1'b0;
  logic prog_rst_n;
  logic [1:0] start, word_valid, word_ready, ccff_head, ccff_clk_en;
  logic [1:0] ccff_tail, busy, done, error;
  logic [7:0] word_data [2];

  logic [11:0] chain   [2] = '{default: '0};
  logic [63:0] bit_log [2] = '{default: '0};
  int          en_cnt  [2] = '{default: 0};
  int          done_cnt[2] = '{default: 0};
  logic        fault_arm = 1'b0;
  int          fault_at  = 0;
  int          checks = 0;
  int          errors = 0;

  always #5 prog_clk = ~prog_clk;

  cfg_chain_loader #(.CHAIN_LEN(CL0), .WORD_W(8)) u_dut8 (
    .prog_clk   (prog_clk),
    .prog_rst_n (prog_rst_n),
    .start      (start[0]),
    .word_data  (word_data[0]),
    .word_valid (word_valid[0]),
    .word_ready (word_ready[0]),
    .ccff_head  (ccff_head[0]),
    .ccff_clk_en(ccff_clk_en[0]),
    .ccff_tail  (ccff_tail[0]),
    .busy       (busy[0]),
    .done       (done[0]),
    .error      (error[0])
  );

  cfg_chain_loader #(.CHAIN_LEN(CL1), .WORD_W(8)) u_dut12 (
    .prog_clk   (prog_clk),
    .prog_rst_n (prog_rst_n),
    .start      (start[1]),
    .word_data  (word_data[1]),
    .word_valid (word_valid[1]),
    .word_ready (word_ready[1]),
    .ccff_head  (ccff_head[1]),
    .ccff_clk_en(ccff_clk_en[1]),
    .ccff_tail  (ccff_tail[1]),
    .busy       (busy[1]),
    .done       (done[1]),
    .error      (error[1])
  );

  // Chain model: the tail is the oldest bit, optionally corrupted on one bit.
  assign ccff_tail[0] = chain[0][CL0-1] ^ (fault_arm && ccff_clk_en[0] && (en_cnt[0] == fault_at));
  assign ccff_tail[1] = chain[1][CL1-1];

  always @(posedge prog_clk) begin
    for (int d = 0; d < 2; d++) begin
      if (ccff_clk_en[d]) begin
        chain[d]   <= {chain[d][10:0], ccff_head[d]};
        bit_log[d] <= {bit_log[d][62:0], ccff_head[d]};
        en_cnt[d]  <= en_cnt[d] + 1;
      end
      if (done[d]) done_cnt[d] <= done_cnt[d] + 1;
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic int clen(input int d);
    return (d == 0) ? CL0 : CL1;
  endfunction

  // Chain contents after a load: the first cl bits of the MSB-first stream.
  function automatic logic [11:0] model_chain(input logic [7:0] w0, input logic [7:0] w1, input int cl);
    logic [15:0] stream;
    logic [11:0] r;
    stream = {w0, w1};
    r = '0;
    for (int i = 0; i < cl; i++) r = {r[10:0], stream[15-i]};
    return r;
  endfunction

  // Every enabled bit of the load, all passes, oldest in the high positions.
  function automatic logic [63:0] model_log(input logic [7:0] w0, input logic [7:0] w1, input int cl);
    logic [15:0] stream;
    logic [63:0] r;
    stream = {w0, w1};
    r = '0;
    for (int p = 0; p < NP; p++)
      for (int i = 0; i < cl; i++) r = {r[62:0], stream[15-i]};
    return r;
  endfunction

  function automatic logic [63:0] log_mask(input int cl);
    return (64'd1 << (NP * cl)) - 64'd1;
  endfunction

  task automatic send_word(input int d, input logic [7:0] w, input int gap);
    int guard;
    word_data[d]  = w;
    word_valid[d] = (gap == 0);
    guard = 0;
    while (!word_ready[d] && guard < 200) begin
      @(negedge prog_clk);
      guard++;
    end
    if (guard >= 200) begin
      checks++; errors++;
      $display("[TB] FAIL send_word_timeout dut%0d: word_ready=0 want 1", d);
      word_valid[d] = 1'b0;
      return;
    end
    for (int k = 0; k < gap; k++) begin
      @(negedge prog_clk);
      if (k > 0) begin
        checks++;
        if (ccff_clk_en[d] !== 1'b0) begin
          errors++;
          $display("[TB] FAIL gap_clk_en dut%0d: got %b want 0", d, ccff_clk_en[d]);
        end
      end
    end
    word_valid[d] = 1'b1;
    @(negedge prog_clk);
    word_valid[d] = 1'b0;
  endtask

  task automatic run_load(input int d, input logic [7:0] w0, input logic [7:0] w1, input int nw, input int gap);
    for (int p = 0; p < NP; p++) begin
      send_word(d, w0, 0);
      if (nw > 1) send_word(d, w1, gap);
    end
  endtask

  task automatic wait_done(input int d, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (done[d]) begin
        ok = 1'b1;
        break;
      end
      @(negedge prog_clk);
    end
  endtask

  task automatic test_reset();
    prog_rst_n = 1'b0;
    start = '0; word_valid = '0;
    word_data[0] = '0; word_data[1] = '0;
    repeat (3) @(negedge prog_clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({word_ready[d], ccff_head[d], ccff_clk_en[d], busy[d], done[d], error[d]} !== 6'b0) begin
        errors++;
        $display("[TB] FAIL reset_outputs dut%0d: got %b want 000000", d,
                 {word_ready[d], ccff_head[d], ccff_clk_en[d], busy[d], done[d], error[d]});
      end
    end
    prog_rst_n = 1'b1;
    @(negedge prog_clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (busy[d] !== 1'b0 || word_ready[d] !== 1'b0) begin
        errors++;
        $display("[TB] FAIL idle_after_reset dut%0d: busy=%b ready=%b want 0 0", d, busy[d], word_ready[d]);
      end
    end
  endtask

  // Common load-and-verify sequence used by the data-pattern tests.
  task automatic load_and_check(input string name, input int d, input logic [7:0] w0,
                                input logic [7:0] w1, input int nw, input int gap);
    int  e0, dn0;
    bit  ok;
    logic [11:0] exp_chain;
    logic [63:0] exp_log, mask;
    e0 = en_cnt[d]; dn0 = done_cnt[d];
    exp_chain = model_chain(w0, w1, clen(d));
    exp_log   = model_log(w0, w1, clen(d));
    mask      = log_mask(clen(d));
    start[d] = 1'b1;
    @(negedge prog_clk);
    start[d] = 1'b0;
    checks++;
    if (busy[d] !== 1'b1 || word_ready[d] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s_fill dut%0d: busy=%b ready=%b want 1 1", name, d, busy[d], word_ready[d]);
    end
    run_load(d, w0, w1, nw, gap);
    wait_done(d, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL %s_done_timeout dut%0d: done=0 want 1", name, d);
    end
    checks++;
    if (busy[d] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s_busy_at_done dut%0d: got %b want 1", name, d, busy[d]);
    end
    @(negedge prog_clk);
    checks++;
    if (done[d] !== 1'b0 || busy[d] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s_after_done dut%0d: done=%b busy=%b want 0 0", name, d, done[d], busy[d]);
    end
    checks++;
    if (en_cnt[d] - e0 != NP * clen(d)) begin
      errors++;
      $display("[TB] FAIL %s_enabled_cycles dut%0d: got %0d want %0d", name, d, en_cnt[d] - e0, NP * clen(d));
    end
    checks++;
    if ((chain[d] & 12'((1 << clen(d)) - 1)) !== exp_chain) begin
      errors++;
      $display("[TB] FAIL %s_chain dut%0d: got %h want %h", name, d, chain[d] & 12'((1 << clen(d)) - 1), exp_chain);
    end
    checks++;
    if ((bit_log[d] & mask) !== exp_log) begin
      errors++;
      $display("[TB] FAIL %s_bit_order dut%0d: got %h want %h", name, d, bit_log[d] & mask, exp_log);
    end
    checks++;
    if (done_cnt[d] - dn0 != 1) begin
      errors++;
      $display("[TB] FAIL %s_done_pulses dut%0d: got %0d want 1", name, d, done_cnt[d] - dn0);
    end
    checks++;
    if (error[d] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s_error dut%0d: got %b want 0", name, d, error[d]);
    end
  endtask

  task automatic test_basic();
    load_and_check("basic", 0, 8'hA5, 8'h00, 1, 0);
  endtask

  task automatic test_stall_partial();
    load_and_check("stall", 1, 8'hF0, 8'h9C, 2, 3);
  endtask

  task automatic test_back_to_back();
    logic [7:0] a, b;
    int gap;
    for (int i = 0; i < 4; i++) begin
      a = 8'($urandom); b = 8'($urandom);
      gap = int'($urandom_range(0, 2));
      load_and_check("rand12", 1, a, b, 2, gap);
      a = 8'($urandom);
      load_and_check("rand8", 0, a, 8'h00, 1, 0);
    end
  endtask

  task automatic test_start_held();
    int e0, dn0;
    bit ok;
    logic [7:0] w;
    w = 8'($urandom);
    e0 = en_cnt[0]; dn0 = done_cnt[0];
    start[0] = 1'b1;
    @(negedge prog_clk);
    run_load(0, w, 8'h00, 1, 0);
    wait_done(0, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL held_done_timeout: done=0 want 1");
    end
    @(negedge prog_clk);
    checks++;
    if (busy[0] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL held_back_to_idle: busy=%b want 0", busy[0]);
    end
    start[0] = 1'b0;
    repeat (3) @(negedge prog_clk);
    checks++;
    if (busy[0] !== 1'b0 || done_cnt[0] - dn0 != 1) begin
      errors++;
      $display("[TB] FAIL held_single_load: busy=%b done_pulses=%0d want 0 1", busy[0], done_cnt[0] - dn0);
    end
    checks++;
    if (en_cnt[0] - e0 != NP * CL0 || chain[0][7:0] !== model_chain(w, 8'h00, CL0)) begin
      errors++;
      $display("[TB] FAIL held_contents: cycles=%0d chain=%h want %0d %h",
               en_cnt[0] - e0, chain[0][7:0], NP * CL0, model_chain(w, 8'h00, CL0));
    end
  endtask

  task automatic test_reset_mid_shift();
    int e0, e1, guard;
    e0 = en_cnt[0];
    start[0] = 1'b1;
    @(negedge prog_clk);
    start[0] = 1'b0;
    send_word(0, 8'hFF, 0);
    guard = 0;
    while (en_cnt[0] - e0 < 3 && guard < 50) begin
      @(negedge prog_clk);
      guard++;
    end
    checks++;
    if (guard >= 50) begin
      errors++;
      $display("[TB] FAIL midreset_timeout: enabled=%0d want 3", en_cnt[0] - e0);
    end
    #1 prog_rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({word_ready[d], ccff_head[d], ccff_clk_en[d], busy[d], done[d], error[d]} !== 6'b0) begin
        errors++;
        $display("[TB] FAIL midreset_outputs dut%0d: got %b want 000000", d,
                 {word_ready[d], ccff_head[d], ccff_clk_en[d], busy[d], done[d], error[d]});
      end
    end
    @(negedge prog_clk);
    prog_rst_n = 1'b1;
    e1 = en_cnt[0];
    repeat (6) @(negedge prog_clk);
    checks++;
    if (en_cnt[0] != e1 || busy[0] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midreset_quiet: pulses=%0d busy=%b want 0 0", en_cnt[0] - e1, busy[0]);
    end
  endtask

`ifdef CFG_CHAIN_READBACK_EN
  task automatic test_readback();
    load_and_check("readback", 0, 8'h3C, 8'h00, 1, 0);
  endtask

  task automatic test_readback_fault();
    bit ok;
    fault_at  = en_cnt[0] + CL0 + 5;
    fault_arm = 1'b1;
    start[0] = 1'b1;
    @(negedge prog_clk);
    start[0] = 1'b0;
    run_load(0, 8'h3C, 8'h00, 1, 0);
    wait_done(0, ok);
    checks++;
    if (!ok || error[0] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL fault_error_at_done: done_seen=%0d error=%b want 1 1", ok, error[0]);
    end
    @(negedge prog_clk);
    fault_arm = 1'b0;
    checks++;
    if (busy[0] !== 1'b0 || error[0] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL fault_sticky_idle: busy=%b error=%b want 0 1", busy[0], error[0]);
    end
    start[0] = 1'b1;
    @(negedge prog_clk);
    start[0] = 1'b0;
    checks++;
    if (error[0] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL fault_cleared_by_start: got %b want 0", error[0]);
    end
    run_load(0, 8'h3C, 8'h00, 1, 0);
    wait_done(0, ok);
    checks++;
    if (!ok || error[0] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL fault_clean_reload: done_seen=%0d error=%b want 1 0", ok, error[0]);
    end
    @(negedge prog_clk);
  endtask
`else
  task automatic test_error_tied();
    bit ok;
    fault_at  = en_cnt[0] + 5;
    fault_arm = 1'b1;
    start[0] = 1'b1;
    @(negedge prog_clk);
    start[0] = 1'b0;
    run_load(0, 8'h3C, 8'h00, 1, 0);
    wait_done(0, ok);
    @(negedge prog_clk);
    fault_arm = 1'b0;
    checks++;
    if (!ok || error[0] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL error_tied: done_seen=%0d error=%b want 1 0", ok, error[0]);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_stall_partial();
    test_back_to_back();
    test_start_held();
`ifdef CFG_CHAIN_READBACK_EN
    test_readback();
    test_readback_fault();
`else
    test_error_tied();
`endif
    test_reset_mid_shift();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
